// File: rtl/ofm_pack_buf.sv
// rtl/ofm_pack_buf.sv - OFM byte packer and frame buffer feeding the DMA write engine
//
// Packs an 8-bit valid/ready byte stream into 32-bit little-endian words and
// stores one whole frame. It then kicks the DMA write engine and returns one
// buffered word per dma_indata_req until dma_done arrives.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   cfg_start/num_words/addr      frame configuration, sampled in IDLE only
//   in_valid/in_ready/in_data     byte stream from the systolic array
//   dma_start/num_trans/start_addr
//                                 DMA write engine launch
//   dma_indata/dma_indata_req     word supply to the DMA engine
//   dma_done                      DMA completion pulse
//   busy, frame_done, cfg_err     status, with frame_done and cfg_err as pulses
//   underrun                      sticky flag for a request beyond the frame
module ofm_pack_buf #(
    parameter int OUT_BITS_TRANS = 13,
    parameter int AXI_WIDTH_DA   = 32,
    parameter int BUF_DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_start,
    input  logic [OUT_BITS_TRANS-1:0] cfg_num_words,
    input  logic [AXI_WIDTH_DA-1:0]   cfg_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    output logic                      dma_start,
    output logic [OUT_BITS_TRANS-1:0] dma_num_trans,
    output logic [AXI_WIDTH_DA-1:0]   dma_start_addr,
    output logic [AXI_WIDTH_DA-1:0]   dma_indata,
    input  logic                      dma_indata_req,
    input  logic                      dma_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      cfg_err,
    output logic                      underrun
);

    localparam int AW = $clog2(BUF_DEPTH);
    // One extra bit so that a full count of BUF_DEPTH is representable.
    localparam int PW = AW + 1;
    localparam logic [OUT_BITS_TRANS-1:0] DEPTH_N = OUT_BITS_TRANS'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, KICK, DRAIN} state_t;

    state_t                  state;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_next;
    logic [1:0]              lane;
    logic [7:0]              lane0;
    logic [7:0]              lane1;
    logic [7:0]              lane2;
    logic                    wr_fire;
    logic                    last_word;
    logic                    rd_avail;
    logic                    cfg_ok;

    logic [AXI_WIDTH_DA-1:0] mem [0:BUF_DEPTH-1];

    assign in_ready  = (state == FILL);
    assign busy      = (state != IDLE);
    assign wr_fire   = (state == FILL) && in_valid && (lane == 2'd3);
    assign wr_next   = wr_ptr + 1'b1;
    // dma_num_trans doubles as the latched frame length.
    assign last_word = (OUT_BITS_TRANS'(wr_next) == dma_num_trans);
    assign rd_avail  = (OUT_BITS_TRANS'(rd_ptr) < dma_num_trans);
    assign cfg_ok    = (cfg_num_words != '0) && (cfg_num_words <= DEPTH_N);

    // Buffer write port, kept free of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= {in_data, lane2, lane1, lane0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            lane           <= '0;
            lane0          <= '0;
            lane1          <= '0;
            lane2          <= '0;
            dma_start      <= 1'b0;
            dma_num_trans  <= '0;
            dma_start_addr <= '0;
            dma_indata     <= '0;
            frame_done     <= 1'b0;
            cfg_err        <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            dma_start  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_ok) begin
                            dma_num_trans  <= cfg_num_words;
                            dma_start_addr <= cfg_addr;
                            wr_ptr         <= '0;
                            rd_ptr         <= '0;
                            lane           <= '0;
                            underrun       <= 1'b0;
                            state          <= FILL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        case (lane)
                            2'd0:    lane0 <= in_data;
                            2'd1:    lane1 <= in_data;
                            2'd2:    lane2 <= in_data;
                            default: ;
                        endcase
                        lane <= lane + 1'b1;
                        if (lane == 2'd3) begin
                            wr_ptr <= wr_next;
                            if (last_word) begin
                                dma_start <= 1'b1;
                                state     <= KICK;
                            end
                        end
                    end
                end
                KICK: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (dma_indata_req) begin
                        if (rd_avail) begin
                            dma_indata <= mem[rd_ptr[AW-1:0]];
                            rd_ptr     <= rd_ptr + 1'b1;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                    if (dma_done) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_pack_buf.sv
// tb/tb_ofm_pack_buf.sv - directed self-checking bench for ofm_pack_buf
module tb_ofm_pack_buf;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [12:0] cfg_num_words = '0;
    logic [31:0] cfg_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        dma_start;
    logic [12:0] dma_num_trans;
    logic [31:0] dma_start_addr;
    logic [31:0] dma_indata;
    logic        dma_indata_req = 1'b0;
    logic        dma_done = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    ofm_pack_buf #(
        .OUT_BITS_TRANS(13),
        .AXI_WIDTH_DA  (32),
        .BUF_DEPTH     (1024)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_start     (cfg_start),
        .cfg_num_words (cfg_num_words),
        .cfg_addr      (cfg_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .dma_start     (dma_start),
        .dma_num_trans (dma_num_trans),
        .dma_start_addr(dma_start_addr),
        .dma_indata    (dma_indata),
        .dma_indata_req(dma_indata_req),
        .dma_done      (dma_done),
        .busy          (busy),
        .frame_done    (frame_done),
        .cfg_err       (cfg_err),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input logic [12:0] n, input logic [31:0] a);
        cfg_num_words = n;
        cfg_addr      = a;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic req_word(input string tag, input logic [31:0] exp);
        dma_indata_req = 1'b1;
        step();
        dma_indata_req = 1'b0;
        check(tag, dma_indata, exp);
    endtask

    task automatic end_frame();
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        step();
        check("frame_done_single", {31'd0, frame_done}, 32'd0);
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37) ^ (k >> 5));
    endfunction

    initial begin
        logic [31:0] exp_w;

        // Reset values
        repeat (2) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_dma_start", {31'd0, dma_start}, 32'd0);
        check("rst_num_trans", {19'd0, dma_num_trans}, 32'd0);
        check("rst_addr", dma_start_addr, 32'd0);
        check("rst_indata", dma_indata, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Basic 4-word frame
        start_cfg(13'd4, 32'h1000_0000);
        check("basic_busy", {31'd0, busy}, 32'd1);
        check("basic_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i <= 16; i++) send(8'(i));
        check("basic_dma_start", {31'd0, dma_start}, 32'd1);
        check("basic_in_ready_kick", {31'd0, in_ready}, 32'd0);
        check("basic_num_trans", {19'd0, dma_num_trans}, 32'd4);
        check("basic_addr", dma_start_addr, 32'h1000_0000);
        step();
        check("basic_dma_start_once", {31'd0, dma_start}, 32'd0);
        req_word("basic_w0", 32'h0403_0201);
        req_word("basic_w1", 32'h0807_0605);
        step();
        check("basic_hold", dma_indata, 32'h0807_0605);
        req_word("basic_w2", 32'h0C0B_0A09);
        req_word("basic_w3", 32'h100F_0E0D);
        check("basic_underrun", {31'd0, underrun}, 32'd0);
        end_frame();

        // Config errors
        start_cfg(13'd0, 32'h0);
        check("err0_pulse", {31'd0, cfg_err}, 32'd1);
        check("err0_idle", {31'd0, busy}, 32'd0);
        step();
        check("err0_single", {31'd0, cfg_err}, 32'd0);
        start_cfg(13'd1025, 32'h0);
        check("err1025_pulse", {31'd0, cfg_err}, 32'd1);
        check("err1025_idle", {31'd0, busy}, 32'd0);
        step();
        check("err1025_single", {31'd0, cfg_err}, 32'd0);

        // cfg_start during FILL is ignored; then overrun on a 2-word frame
        start_cfg(13'd2, 32'h3000_0040);
        send(8'hA1); send(8'hA2); send(8'hA3);
        cfg_num_words = 13'd7;
        cfg_addr      = 32'hDEAD_0000;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
        check("fillcfg_busy", {31'd0, busy}, 32'd1);
        check("fillcfg_num", {19'd0, dma_num_trans}, 32'd2);
        check("fillcfg_err", {31'd0, cfg_err}, 32'd0);
        send(8'hA4); send(8'hA5); send(8'hA6); send(8'hA7); send(8'hA8);
        check("ovr_dma_start", {31'd0, dma_start}, 32'd1);
        check("ovr_num", {19'd0, dma_num_trans}, 32'd2);
        check("ovr_addr", dma_start_addr, 32'h3000_0040);
        step();
        dma_indata_req = 1'b1;
        step();
        check("ovr_w0", dma_indata, 32'hA4A3_A2A1);
        step();
        check("ovr_w1", dma_indata, 32'hA8A7_A6A5);
        check("ovr_no_underrun", {31'd0, underrun}, 32'd0);
        step();
        dma_indata_req = 1'b0;
        check("ovr_underrun", {31'd0, underrun}, 32'd1);
        check("ovr_hold", dma_indata, 32'hA8A7_A6A5);
        end_frame();
        check("ovr_sticky", {31'd0, underrun}, 32'd1);

        // Next accepted cfg_start clears underrun; flow control after 1-word frame
        start_cfg(13'd1, 32'h0000_0044);
        check("ovr_cleared", {31'd0, underrun}, 32'd0);
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        check("flow_ready_kick", {31'd0, in_ready}, 32'd0);
        step();
        check("flow_ready_drain", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        req_word("flow_w0", 32'h1413_1211);
        end_frame();

        // Full depth with random input gaps, drained in 4 back-to-back bursts
        start_cfg(13'd1024, 32'h2000_0000);
        for (int k = 0; k < 4096; k++) begin
            repeat ($urandom_range(0, 2)) step();
            send(pat(k));
        end
        check("full_dma_start", {31'd0, dma_start}, 32'd1);
        check("full_num", {19'd0, dma_num_trans}, 32'd1024);
        step();
        for (int b = 0; b < 4; b++) begin
            dma_indata_req = 1'b1;
            for (int j = 0; j < 256; j++) begin
                step();
                exp_w = {pat(4 * (256 * b + j) + 3), pat(4 * (256 * b + j) + 2),
                         pat(4 * (256 * b + j) + 1), pat(4 * (256 * b + j))};
                check($sformatf("full_w%0d", 256 * b + j), dma_indata, exp_w);
            end
            dma_indata_req = 1'b0;
            repeat (3) step();
        end
        check("full_underrun", {31'd0, underrun}, 32'd0);
        end_frame();

        // Reset mid-DRAIN
        start_cfg(13'd1, 32'h0000_0050);
        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        step();
        req_word("rstd_w0", 32'h2423_2221);
        dma_indata_req = 1'b1;
        step();
        dma_indata_req = 1'b0;
        check("rstd_underrun_set", {31'd0, underrun}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rstd_busy", {31'd0, busy}, 32'd0);
        check("rstd_in_ready", {31'd0, in_ready}, 32'd0);
        check("rstd_num", {19'd0, dma_num_trans}, 32'd0);
        check("rstd_addr", dma_start_addr, 32'd0);
        check("rstd_indata", dma_indata, 32'd0);
        check("rstd_underrun", {31'd0, underrun}, 32'd0);
        check("rstd_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        start_cfg(13'd1, 32'h0000_0060);
        check("post_busy", {31'd0, busy}, 32'd1);
        check("post_addr", dma_start_addr, 32'h0000_0060);
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        check("post_dma_start", {31'd0, dma_start}, 32'd1);
        step();
        req_word("post_w0", 32'h3433_3231);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
